key_debounce: RTL and testbench
===============================

# key_debounce

Conditions a raw push-button or switch input into a clean, single-clock-domain level for the D input of the downstream asynchronous-reset D flip-flop stage. The block synchronises the input and filters contact bounce with a counter-based state machine. It also produces one-cycle press and release pulses and an 8-bit press count for board-level display.

## Interface
- DEBOUNCE_CYCLES, default 2000000 (20 ms at 100 MHz): number of consecutive cycles the synchronised input must hold a new value before it is accepted; must be ≥ 2.
- CNT_W, default 21: counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- CLK  input  1  sole clock; all state updates on rising edge.
- RST_n  input  1  reset is asynchronous and active-low; forces every register to its reset value immediately.
- KEY_IN  input  1  raw button level, asynchronous to CLK; 1 = pressed.
- KEY_STATE  output  1  debounced level, registered; drives D of the downstream flip-flop.
- KEY_RISE  output  1  one-cycle pulse on an accepted 0→1 transition.
- KEY_FALL  output  1  one-cycle pulse on an accepted 1→0 transition.
- BUSY  output  1  high while a candidate transition is being timed (WAIT states).
- PRESS_CNT  output  8  count of accepted rises; wraps 255→0.

## Operation
- Synchroniser: two flip-flops, sync1 ← KEY_IN, sync2 ← sync1; both reset to 0. The FSM uses only sync2.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. Reset state is IDLE_LOW.
- IDLE_LOW, sync2 = 1 → WAIT_HIGH, cnt ← 1. Otherwise stay, cnt ← 0.
- WAIT_HIGH:
  - sync2 = 0 → IDLE_LOW, cnt ← 0. No outputs change (glitch rejected).
  - sync2 = 1 and cnt < DEBOUNCE_CYCLES−1 → cnt ← cnt+1.
  - sync2 = 1 and cnt = DEBOUNCE_CYCLES−1 → IDLE_HIGH, cnt ← 0, KEY_STATE ← 1, KEY_RISE ← 1, PRESS_CNT ← PRESS_CNT+1 (mod 256).
- IDLE_HIGH / WAIT_LOW mirror the above with the polarity inverted. Acceptance sets KEY_STATE ← 0 and KEY_FALL ← 1; PRESS_CNT is unchanged.
- KEY_RISE and KEY_FALL are registered and default to 0 every cycle. They are never high together.
- BUSY = 1 exactly when the state is WAIT_HIGH or WAIT_LOW (decoded from registered state).
- The counter never exceeds DEBOUNCE_CYCLES−1 and never wraps.
- Reset values: sync1 = sync2 = 0, state IDLE_LOW, cnt = 0, KEY_STATE = 0, KEY_RISE = 0, KEY_FALL = 0, BUSY = 0, PRESS_CNT = 0.
- RST_n asserted mid-WAIT or during a pulse cycle: all outputs clear immediately and the pending transition is discarded.
- RST_n released with KEY_IN held high: the input is treated as a new press. The full debounce period elapses, then KEY_RISE fires and PRESS_CNT becomes 1.

## Timing
- Let KEY_IN reach a new value before rising edge 0 and then hold it:
  - sync2 updates after edge 1.
  - The FSM enters WAIT after edge 2 (cnt = 1).
  - The accepting edge is DEBOUNCE_CYCLES+1; KEY_STATE, the pulse and PRESS_CNT are visible after it.
  - Total latency is DEBOUNCE_CYCLES+2 edges including synchroniser stages.
- A bounce (sync2 reverting) on any edge before acceptance returns the FSM to IDLE. The next candidate then restarts its count from 1.
- Each pulse is exactly 1 cycle wide. The earliest opposite-direction pulse is DEBOUNCE_CYCLES+1 cycles later.
- Combinational paths from inputs to outputs: none.

## Test plan
- Reset: hold RST_n = 0 with KEY_IN = 1 → all outputs 0. Release with DEBOUNCE_CYCLES = 4 → KEY_RISE high for 1 cycle after edge 5, KEY_STATE = 1, PRESS_CNT = 1.
- Clean press/release, DEBOUNCE_CYCLES = 4:
  - KEY_IN 0→1 before edge 0 → BUSY high after edge 2, KEY_STATE = 1 and KEY_RISE pulse after edge 5.
  - Release → KEY_FALL pulse 6 edges later, PRESS_CNT unchanged.
- Bounce: KEY_IN high for 2 cycles, low 1, high 5 → exactly one KEY_RISE. It occurs 5 edges after the final rising edge of sync2's input; no KEY_FALL.
- Short glitch: KEY_IN high for 2 cycles only → BUSY pulses, KEY_STATE stays 0, no KEY_RISE or KEY_FALL, PRESS_CNT stays 0.
- Wrap: 256 clean presses → PRESS_CNT reads 0 after the 256th KEY_RISE, with 255 immediately before.
- Mid-operation reset: assert RST_n while BUSY = 1 in WAIT_LOW (KEY_STATE = 1) → KEY_STATE, BUSY, PRESS_CNT = 0 asynchronously; no KEY_FALL pulse is emitted.

Source files
------------

// File: rtl/key_debounce_if.sv
// Button-conditioning bus: raw key level in, debounced level, edge pulses,
// busy flag and press count out. master = key source/observer, slave = debouncer.
interface key_debounce_if;
  logic       KEY_IN;
  logic       KEY_STATE;
  logic       KEY_RISE;
  logic       KEY_FALL;
  logic       BUSY;
  logic [7:0] PRESS_CNT;

  modport master (
    output KEY_IN,
    input  KEY_STATE, KEY_RISE, KEY_FALL, BUSY, PRESS_CNT
  );

  modport slave (
    input  KEY_IN,
    output KEY_STATE, KEY_RISE, KEY_FALL, BUSY, PRESS_CNT
  );
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus counter FSM that debounces a raw key and emits edge pulses.
// Latency DEBOUNCE_CYCLES+2 edges from a held input change to KEY_STATE; no backpressure.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int CNT_W           = 21
) (
  input  logic          CLK,
  input  logic          RST_n,
  key_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             key_state;
  logic             key_rise;
  logic             key_fall;
  logic [7:0]       press_cnt;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.KEY_IN;
      sync2 <= sync1;
    end
  end

  // Pulses default low every cycle so each accepted edge yields exactly one cycle.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= IDLE_LOW;
      cnt       <= '0;
      key_state <= 1'b0;
      key_rise  <= 1'b0;
      key_fall  <= 1'b0;
      press_cnt <= 8'd0;
    end else begin
      key_rise <= 1'b0;
      key_fall <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (sync2) begin
            state <= WAIT_HIGH;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!sync2) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE_HIGH;
            cnt       <= '0;
            key_state <= 1'b1;
            key_rise  <= 1'b1;
            press_cnt <= press_cnt + 8'd1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!sync2) begin
            state <= WAIT_LOW;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_LOW: begin
          if (sync2) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE_LOW;
            cnt       <= '0;
            key_state <= 1'b0;
            key_fall  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.KEY_STATE = key_state;
  assign bus.KEY_RISE  = key_rise;
  assign bus.KEY_FALL  = key_fall;
  assign bus.BUSY      = (state == WAIT_HIGH) || (state == WAIT_LOW);
  assign bus.PRESS_CNT = press_cnt;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: vector table, hand-written corner sequences and random
// key activity, all compared against a run-length reference model.
module tb_key_debounce;
  localparam int D = 4;

  logic CLK   = 1'b0;
  logic RST_n = 1'b0;

  key_debounce_if kif ();

  key_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .bus  (kif)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: the accepted level flips once the key, seen two edges late,
  // has differed from it on D consecutive edges.
  bit m_h1, m_h2, m_lvl, m_rise, m_fall;
  int m_run, m_cnt;

  // Observation counters fed from the DUT outputs.
  int edge_no, n_rise, n_fall, n_busy, last_rise_edge;

  typedef struct {
    bit key;
    int cycles;
    bit st;
    bit busy;
    bit rise;
    bit fall;
    int cnt;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_h1 = 0; m_h2 = 0; m_lvl = 0; m_rise = 0; m_fall = 0; m_run = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit k);
    bit u;
    u = m_h2;
    m_rise = 0;
    m_fall = 0;
    if (u != m_lvl) m_run++;
    else m_run = 0;
    if (m_run == D) begin
      m_lvl = u;
      m_run = 0;
      if (u) begin
        m_rise = 1;
        m_cnt  = (m_cnt + 1) % 256;
      end else begin
        m_fall = 1;
      end
    end
    m_h2 = m_h1;
    m_h1 = k;
  endtask

  task automatic cmp_all();
    chk("model_key_state", {31'd0, kif.KEY_STATE}, {31'd0, m_lvl});
    chk("model_key_rise",  {31'd0, kif.KEY_RISE},  {31'd0, m_rise});
    chk("model_key_fall",  {31'd0, kif.KEY_FALL},  {31'd0, m_fall});
    chk("model_busy",      {31'd0, kif.BUSY},      (m_run != 0) ? 32'd1 : 32'd0);
    chk("model_press_cnt", {24'd0, kif.PRESS_CNT}, m_cnt);
  endtask

  task automatic clear_stats();
    n_rise = 0; n_fall = 0; n_busy = 0; last_rise_edge = -1;
  endtask

  task automatic step(input bit k);
    kif.KEY_IN = k;
    @(posedge CLK);
    model_edge(k);
    #1;
    cmp_all();
    edge_no++;
    if (kif.KEY_RISE === 1'b1) begin
      n_rise++;
      last_rise_edge = edge_no;
    end
    if (kif.KEY_FALL === 1'b1) n_fall++;
    if (kif.BUSY === 1'b1) n_busy++;
  endtask

  task automatic hold(input bit k, input int n);
    for (int i = 0; i < n; i++) step(k);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_key_state"}, {31'd0, kif.KEY_STATE}, 32'd0);
    chk({tag, "_key_rise"},  {31'd0, kif.KEY_RISE},  32'd0);
    chk({tag, "_key_fall"},  {31'd0, kif.KEY_FALL},  32'd0);
    chk({tag, "_busy"},      {31'd0, kif.BUSY},      32'd0);
    chk({tag, "_press_cnt"}, {24'd0, kif.PRESS_CNT}, 32'd0);
  endtask

  // Called one time unit after an edge: asserts reset mid-cycle, checks the
  // asynchronous clear, holds two edges, releases mid-cycle.
  task automatic do_reset(input bit k, input string tag);
    kif.KEY_IN = k;
    #2;
    RST_n = 1'b0;
    model_reset();
    #1;
    check_zero(tag);
    @(posedge CLK);
    #1;
    chk({tag, "_hold_fall"}, {31'd0, kif.KEY_FALL}, 32'd0);
    @(posedge CLK);
    #1;
    check_zero({tag, "_held"});
    RST_n = 1'b1;
  endtask

  initial begin
    vt[0]  = '{0, 3, 0, 0, 0, 0, 0};
    vt[1]  = '{1, 2, 0, 0, 0, 0, 0};
    vt[2]  = '{0, 3, 0, 0, 0, 0, 0};
    vt[3]  = '{1, 6, 1, 0, 1, 0, 1};
    vt[4]  = '{0, 6, 0, 0, 0, 1, 1};
    vt[5]  = '{1, 4, 0, 1, 0, 0, 1};
    vt[6]  = '{1, 2, 1, 0, 1, 0, 2};
    vt[7]  = '{1, 3, 1, 0, 0, 0, 2};
    vt[8]  = '{0, 1, 1, 0, 0, 0, 2};
    vt[9]  = '{1, 3, 1, 0, 0, 0, 2};
    vt[10] = '{0, 6, 0, 0, 0, 1, 2};

    edge_no = 0;
    clear_stats();
    model_reset();

    // Reset held with the key pressed, then released: a fresh press is timed.
    kif.KEY_IN = 1'b1;
    RST_n      = 1'b0;
    #1;
    check_zero("rst_async");
    repeat (2) @(posedge CLK);
    #1;
    check_zero("rst_held");
    RST_n = 1'b1;
    hold(1'b1, 5);
    chk("rst_release_no_early_rise", {31'd0, kif.KEY_RISE}, 32'd0);
    step(1'b1);
    chk("rst_release_rise",  {31'd0, kif.KEY_RISE},  32'd1);
    chk("rst_release_cnt",   {24'd0, kif.PRESS_CNT}, 32'd1);
    chk("rst_release_state", {31'd0, kif.KEY_STATE}, 32'd1);
    step(1'b1);
    chk("rst_release_pulse_width", {31'd0, kif.KEY_RISE}, 32'd0);

    // Vector table from a clean reset.
    do_reset(1'b0, "tbl_rst");
    for (int v = 0; v < 11; v++) begin
      hold(vt[v].key, vt[v].cycles);
      chk($sformatf("vec%0d_state", v), {31'd0, kif.KEY_STATE}, {31'd0, vt[v].st});
      chk($sformatf("vec%0d_busy", v),  {31'd0, kif.BUSY},      {31'd0, vt[v].busy});
      chk($sformatf("vec%0d_rise", v),  {31'd0, kif.KEY_RISE},  {31'd0, vt[v].rise});
      chk($sformatf("vec%0d_fall", v),  {31'd0, kif.KEY_FALL},  {31'd0, vt[v].fall});
      chk($sformatf("vec%0d_cnt", v),   {24'd0, kif.PRESS_CNT}, vt[v].cnt);
    end

    // Short glitch: two high cycles produce two BUSY cycles and nothing else.
    clear_stats();
    hold(1'b1, 2);
    hold(1'b0, 6);
    chk("glitch_busy_cycles", n_busy, 2);
    chk("glitch_rises", n_rise, 0);
    chk("glitch_falls", n_fall, 0);
    chk("glitch_state", {31'd0, kif.KEY_STATE}, 32'd0);
    chk("glitch_cnt",   {24'd0, kif.PRESS_CNT}, 32'd2);

    // Bounce: high 2, low 1, high and held; one rise, 5 edges after the last rise.
    begin
      int t_last;
      clear_stats();
      hold(1'b1, 2);
      step(1'b0);
      step(1'b1);
      t_last = edge_no;
      hold(1'b1, 7);
      chk("bounce_rises", n_rise, 1);
      chk("bounce_falls", n_fall, 0);
      chk("bounce_delay", last_rise_edge - t_last, 5);
      chk("bounce_cnt", {24'd0, kif.PRESS_CNT}, 32'd3);
      hold(1'b0, 8);
    end

    // Random key activity with random hold lengths around the debounce window.
    for (int r = 0; r < 120; r++) begin
      bit lvl;
      lvl = 1'($urandom_range(0, 1));
      hold(lvl, $urandom_range(1, 7));
    end
    hold(1'b0, 8);

    // Counter wrap over 256 clean presses.
    do_reset(1'b0, "wrap_rst");
    for (int i = 1; i <= 256; i++) begin
      hold(1'b1, 5);
      if (i == 256) chk("wrap_before_last", {24'd0, kif.PRESS_CNT}, 32'd255);
      step(1'b1);
      if (i == 255) begin
        chk("wrap_255_rise", {31'd0, kif.KEY_RISE},  32'd1);
        chk("wrap_255_cnt",  {24'd0, kif.PRESS_CNT}, 32'd255);
      end
      if (i == 256) begin
        chk("wrap_256_rise", {31'd0, kif.KEY_RISE},  32'd1);
        chk("wrap_256_cnt",  {24'd0, kif.PRESS_CNT}, 32'd0);
      end
      hold(1'b0, 6);
    end

    // Reset while timing a release: pending fall is discarded.
    do_reset(1'b0, "mid_pre");
    hold(1'b1, 6);
    chk("mid_pressed", {31'd0, kif.KEY_STATE}, 32'd1);
    hold(1'b0, 3);
    chk("mid_busy",  {31'd0, kif.BUSY},      32'd1);
    chk("mid_state", {31'd0, kif.KEY_STATE}, 32'd1);
    do_reset(1'b0, "mid_rst");
    clear_stats();
    hold(1'b0, 8);
    chk("mid_no_fall", n_fall, 0);
    chk("mid_no_rise", n_rise, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
